// File: rtl/matrix_mac_engine_if.sv
// Bus bundle for matrix_mac_engine: start/clear control, read ports of the A and B memories,
// write port of the C memory and the status flags.
`timescale 1ns/1ps
interface matrix_mac_engine_if #(
  parameter int RES_W = 18
);
  logic             start;
  logic             clear;
  logic             read_A;
  logic [31:0]      read_address_A;
  logic [7:0]       data_A;
  logic             read_B;
  logic [31:0]      read_address_B;
  logic [7:0]       data_B;
  logic             write_C;
  logic [31:0]      write_address_C;
  logic [RES_W-1:0] write_value_C;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    input  start, clear, data_A, data_B,
    output read_A, read_address_A, read_B, read_address_B,
    output write_C, write_address_C, write_value_C, busy, done, overflow
  );

  modport slave (
    output start, clear, data_A, data_B,
    input  read_A, read_address_A, read_B, read_address_B,
    input  write_C, write_address_C, write_value_C, busy, done, overflow
  );
endinterface

// File: rtl/matrix_mac_engine.sv
// Sequential single-MAC matrix multiplier C = A x B on unsigned 8-bit elements, row-major.
// Optional feature macro MAC_SATURATE_EN: saturating accumulator with sticky overflow flag.
`timescale 1ns/1ps
module matrix_mac_engine #(
  parameter int ROW_A = 2,
  parameter int COL_A = 2,
  parameter int COL_B = 2,
  parameter int RES_W = 18
) (
  input logic             clk,
  input logic             rst,
  matrix_mac_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_MAC, S_WRITE, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic             start_q;
  logic             start_rise;
  logic [31:0]      i_q, j_q, k_q;
  logic [RES_W-1:0] acc;
  logic [15:0]      prod;
  logic             last_i, last_j, last_k;

  assign start_rise = bus.start & ~start_q;
  assign last_i     = (i_q == 32'(ROW_A - 1));
  assign last_j     = (j_q == 32'(COL_B - 1));
  assign last_k     = (k_q == 32'(COL_A - 1));
  assign prod       = 16'(bus.data_A) * 16'(bus.data_B);

  function automatic logic [RES_W-1:0] mac_acc(input logic [RES_W-1:0] a, input logic [15:0] p);
`ifdef MAC_SATURATE_EN
    logic [RES_W:0] s;
    s = {1'b0, a} + (RES_W+1)'(p);
    return s[RES_W] ? {RES_W{1'b1}} : s[RES_W-1:0];
`else
    return a + RES_W'(p);
`endif
  endfunction

`ifdef MAC_SATURATE_EN
  logic ovf_q;

  function automatic logic mac_ovf(input logic [RES_W-1:0] a, input logic [15:0] p);
    logic [RES_W:0] s;
    s = {1'b0, a} + (RES_W+1)'(p);
    return s[RES_W];
  endfunction

  // Sticky until reset or the next run start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (state == S_IDLE && start_rise)
      ovf_q <= 1'b0;
    else if (state == S_MAC && mac_ovf(acc, prod))
      ovf_q <= 1'b1;
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_rise) state_nxt = S_READ;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_MAC;
      S_MAC:   state_nxt = last_k ? S_WRITE : S_READ;
      S_WRITE: state_nxt = (last_i && last_j) ? S_DONE : S_READ;
      S_DONE:  if (bus.clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reads are held from READ through MAC so slow memories settle before the sampling edge
  always_comb begin
    bus.read_A          = 1'b0;
    bus.read_B          = 1'b0;
    bus.read_address_A  = '0;
    bus.read_address_B  = '0;
    bus.write_C         = 1'b0;
    bus.write_address_C = '0;
    bus.write_value_C   = '0;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    case (state)
      S_READ, S_WAIT, S_MAC: begin
        bus.read_A         = 1'b1;
        bus.read_B         = 1'b1;
        bus.read_address_A = i_q * 32'(COL_A) + k_q;
        bus.read_address_B = k_q * 32'(COL_B) + j_q;
        bus.busy           = 1'b1;
      end
      S_WRITE: begin
        bus.write_C         = 1'b1;
        bus.write_address_C = i_q * 32'(COL_B) + j_q;
        bus.write_value_C   = acc;
        bus.busy            = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc     <= '0;
    end else begin
      start_q <= bus.start;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
            acc <= '0;
          end
        end
        S_MAC: begin
          acc <= mac_acc(acc, prod);
          k_q <= last_k ? 32'd0 : k_q + 32'd1;
        end
        // i wraps with j on the last element so the next run starts from C[0][0]
        S_WRITE: begin
          acc <= '0;
          if (last_j) begin
            j_q <= '0;
            i_q <= last_i ? 32'd0 : i_q + 32'd1;
          end else begin
            j_q <= j_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_mac_engine.md
# matrix_mac_engine

Downstream compute stage for the UART loaders. Once matrices A and B have been written into their memories, it reads them through their read ports and computes C = A × B on unsigned 8-bit elements with a single sequential multiply-accumulate unit. It writes each C element, row-major, into a result memory for the transmit path to send.

## Interface
Parameters:
- ROW_A, 2, rows of A and of C
- COL_A, 2, columns of A, equal to the rows of B (inner dimension)
- COL_B, 2, columns of B and of C
- RES_W, 18, accumulator and result width in bits

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  level input (loader written_completed signals ANDed together); a rising edge launches a run
- clear  in  1  in DONE, returns the block to IDLE
- read_A  out  1  read enable, memory A
- read_address_A  out  32  element index into A
- data_A  in  8  read data from A
- read_B  out  1  read enable, memory B
- read_address_B  out  32  element index into B
- data_B  in  8  read data from B
- write_C  out  1  one-cycle write strobe to the result memory
- write_address_C  out  32  element index into C
- write_value_C  out  RES_W  result value
- busy  out  1  high in READ, WAIT, MAC and WRITE
- done  out  1  high in DONE
- overflow  out  1  sticky accumulator overflow flag (see Configuration)

## Operation
- Addressing is row-major, matching the loader write order:
  - A[i][k] is at i*COL_A+k
  - B[k][j] is at k*COL_B+j
  - C[i][j] is at i*COL_B+j
- Loop order: i outer, j middle, k inner. Counters i, j and k reset to 0.
- FSM states: IDLE, READ, WAIT, MAC, WRITE, DONE.
- IDLE:
  - A start rising edge goes to READ. Detection uses start_q, which resets to 0, so start high at reset release counts as an edge.
  - All strobes are low.
- READ:
  - read_A and read_B go high with their addresses.
  - Next state is WAIT.
- WAIT:
  - Reads and addresses are held.
  - Next state is MAC.
- MAC:
  - Reads and addresses are held.
  - The clock edge that ends MAC loads acc with acc + data_A*data_B. The product is 16 bits, zero-extended to RES_W.
  - If k < COL_A−1: increment k and go to READ. Otherwise clear k and go to WRITE.
- WRITE:
  - write_C=1 for exactly one cycle, with write_value_C=acc and write_address_C=i*COL_B+j.
  - acc clears at the end of WRITE.
  - Then j increments. When j wraps, i increments.
  - After the last element (i=ROW_A−1, j=COL_B−1), the next state is DONE. Otherwise it is READ.
- DONE:
  - done=1 and busy=0.
  - Remains in DONE until clear=1, then goes to IDLE. While in DONE, start edges are ignored.
- Start edges in any state other than IDLE are ignored.
- Memories must present data within 2 cycles of read assertion. The engine samples data only at the edge that ends MAC.

## Timing
- Reset values:
  - state IDLE; acc, i, j, k and start_q all 0.
  - All outputs 0: strobes, addresses, write_value_C, busy, done, overflow.
- Per C element: 3*COL_A+1 cycles. Per run: ROW_A*COL_B*(3*COL_A+1) cycles from the edge that samples start to the edge that enters DONE.
- Reset mid-run:
  - Immediate return to IDLE; no further writes.
  - Memory contents are unaffected. Results already written stay in place.
- clear asserted outside DONE has no effect.
- Simultaneous clear and start edge in DONE: go to IDLE only. A new run needs a fresh rising edge of start.
- overflow clears when a new run starts (IDLE→READ).

## Configuration
- MAC_SATURATE_EN defined:
  - If an accumulate exceeds 2^RES_W−1, acc saturates at 2^RES_W−1 and overflow is set.
  - overflow stays set until reset or the next run start.
- MAC_SATURATE_EN undefined:
  - acc wraps modulo 2^RES_W.
  - overflow is tied to 0.

## Test plan
- Basic 2×2 (defaults): A=[1,2,3,4], B=[5,6,7,8], start rising edge -> four writes at addresses 0..3 with values 19, 22, 43, 50; done rises 28 cycles after start is sampled; overflow=0.
- Maximum values (defaults): all A and B elements 255 -> every C element 130050; overflow=0.
- Overflow with RES_W=16, all elements 255 -> with MAC_SATURATE_EN, C=65535 and overflow=1; without it, C=64514 and overflow=0.
- Reset mid-run: assert rst during the second MAC of element 1 -> only C[0] has been written (value 19); outputs return to 0; state IDLE; a fresh start rising edge produces all four correct values.
- Ignored starts: toggle start during busy and during DONE -> no restart and no extra write_C pulses; clear pulse -> IDLE; next rising edge repeats the run.
- Non-square case with ROW_A=2, COL_A=3, COL_B=1: A=[1,2,3,4,5,6], B=[1,1,1] -> C=[6,15]; done after 20 cycles.
